rtc_stim_gen: RTL
=================

// Module: rtc_stim_gen
// PURPOSE
//  Parametrised, clocked stimulus source for the RTC/chronometer display path; successor to the static switch-selected patterns.
//  Drives the same field set (time, date, chronometer, run counter, cursors, page) with live BCD counting.
//  Also provides chronometer countdown, cursor sweep and preset loads, so the display/VGA chain can be exercised on board and in sim.
// PARAMETERS
//  TICK_DIV   100_000_000  clk cycles per 1 s tick (>=2); sim uses 4
//  CUR_MAX    3            highest cursor value for p_ho/p_fe/p_cr sweep (<=7)
// PORTS
//  clk        in   1  system clock, single clock domain
//  reset      in   1  synchronous, active-high
//  SW         in   3  mode select
//  fmt12      in   1  1 = 12 h display format, 0 = 24 h
//  d_pg       out  2  display page
//  p_cr,p_fe,p_ho out 3 cursor positions: chrono/date/hour screens
//  CRONO_FIN,AMPM,FORMATO out 1 countdown done / PM flag / registered fmt12
//  HREL,MREL,SREL,DIA,MES,ANIO out 8 each  BCD time and date
//  HCRON,MCRON,SCRON,HRUN,MRUN,SRUN out 8 each  BCD chrono preset / running count
// BEHAVIOUR
//  - All outputs are registered; no combinational path from SW/fmt12 to outputs.
//  - Reset values:
//    - HREL/MREL/SREL=00, DIA=01, MES=01, ANIO=00.
//    - HCRON=00, MCRON=01, SCRON=30, HRUN/MRUN/SRUN=00.
//    - CRONO_FIN=0, AMPM=0, FORMATO=0, d_pg=0, p_*=0. Prescaler=0.
//  - tick: prescaler counts 0..TICK_DIV-1; tick=1 in the cycle the count is TICK_DIV-1.
//    - With SW=111, tick=1 every cycle.
//  - Mode change (SW != registered SW_q): prescaler cleared that edge; no tick applied on that edge.
//  - SW modes:
//    - 000: freeze, all outputs hold.
//    - 001: run clock.
//    - 010: chrono countdown.
//    - 011: run clock and chrono together.
//    - 100: cursor sweep.
//    - 101: load preset 11:22:33 28/02/24, then freeze.
//    - 110: load preset 23:59:50 31/12/99, then freeze.
//    - 111: run clock at tick-every-cycle.
//  - Clock run, per tick, on the same edge:
//    - SREL+1 (BCD, 59->00 carries to MREL); MREL 59->00 carries to hour; hour24 23->00 carries to date.
//  - Date:
//    - Month lengths: 31 for 01,03,05,07,08,10,12; 30 for 04,06,09,11; 02 has 28, or 29 when BCD ANIO mod 4 = 0 (00 counts as leap).
//    - Last day -> DIA=01 and MES+1; MES 12->01 and ANIO+1; ANIO 99->00.
//  - Hour display:
//    - Internal hour24 is always BCD 00..23. AMPM = hour24>=12.
//    - FORMATO=0: HREL = hour24.
//    - FORMATO=1: HREL = 12 for hour24 00 and 12; hour24-12 for 13..23; else hour24.
//    - FORMATO follows fmt12 one cycle late. HREL is recomputed on the same edge FORMATO updates.
//  - Chrono:
//    - On entry to 010/011, HRUN/MRUN/SRUN <= HCRON/MCRON/SCRON and CRONO_FIN <= 0.
//    - Each tick, decrement as BCD h:m:s (SRUN 00 borrows to 59, MRUN 00 borrows to 59).
//    - The edge that reaches 00:00:00 sets CRONO_FIN=1; RUN then holds at zero.
//    - Entering with preset 00:00:00 sets CRONO_FIN=1 on the following edge.
//    - CRONO_FIN clears only on reset or a chrono re-entry.
//  - Cursor sweep, per tick:
//    - d_pg+1 mod 4.
//    - p_ho, p_fe and p_cr each advance 0..CUR_MAX and wrap to 0, all in lockstep.
//    - Other fields hold.
//  - Preset load (101/110): takes effect on the mode-change edge; nothing else changes.
//  - reset has priority over every mode and tick, including mid-countdown and mid-carry.
// TESTING (TICK_DIV=4)
//  1. Reset, SW=000, 20 cycles -> all outputs at reset values; no change.
//  2. SW=110, then SW=001, 40 ticks -> 00:00:30 01/01/00. Check the year/month/day rollover edge.
//  3. SW=101, then SW=111, fmt12=0 -> date 29/02/24 at midnight, then 01/03/24.
//     Also: ANIO=23, 28/02 -> 01/03.
//  4. HCRON=00 MCRON=01 SCRON=30 (reset), SW=010, 90 ticks:
//     - CRONO_FIN rises exactly on the tick hitting 00:00:00.
//     - 5 further ticks: RUN=000000, FIN=1.
//     - SW=000 then 010: FIN=0, RUN=000130.
//  5. fmt12 toggled at hour24=00,12,13,23 -> HREL=12,12,01,11 and AMPM=0,1,1,1.
//     With fmt12=0, HREL equals hour24.
//  6. SW=100 for 9 ticks -> d_pg=1, p_*=1 (wrap at 3). Assert reset mid-sweep -> all zero next edge.

Source files
------------

// File: rtl/rtc_stim_gen.sv
// rtc_stim_gen: clocked BCD stimulus source for the RTC/chrono display path.
// Ports: clk, reset (sync, active-high), SW (mode), fmt12 (12/24 h select);
//   d_pg (page), p_cr/p_fe/p_ho (cursors), CRONO_FIN, AMPM, FORMATO,
//   HREL/MREL/SREL, DIA/MES/ANIO, HCRON/MCRON/SCRON, HRUN/MRUN/SRUN (BCD).
module rtc_stim_gen #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned CUR_MAX  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] SW,
    input  logic       fmt12,
    output logic [1:0] d_pg,
    output logic [2:0] p_cr,
    output logic [2:0] p_fe,
    output logic [2:0] p_ho,
    output logic       CRONO_FIN,
    output logic       AMPM,
    output logic       FORMATO,
    output logic [7:0] HREL,
    output logic [7:0] MREL,
    output logic [7:0] SREL,
    output logic [7:0] DIA,
    output logic [7:0] MES,
    output logic [7:0] ANIO,
    output logic [7:0] HCRON,
    output logic [7:0] MCRON,
    output logic [7:0] SCRON,
    output logic [7:0] HRUN,
    output logic [7:0] MRUN,
    output logic [7:0] SRUN
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [7:0] CRON_H = 8'h00;
    localparam logic [7:0] CRON_M = 8'h01;
    localparam logic [7:0] CRON_S = 8'h30;

    logic [2:0]    sw_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic [7:0]    day_q, day_d, mon_q, mon_d, yr_q, yr_d;
    logic [7:0]    rh_q, rh_d, rm_q, rm_d, rs_q, rs_d;
    logic          fin_q, fin_d;
    logic [1:0]    pg_q, pg_d;
    logic [2:0]    cur_q, cur_d;
    logic          fmt_q;
    logic [7:0]    hrel_q, hrel_d;
    logic          ampm_q, ampm_d;
    logic          sw_chg, presc_wrap, tick;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
        else                r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // Decimal year divisible by 4: even tens with 0/4/8, odd tens with 2/6.
    function automatic logic leap(input logic [7:0] y);
        logic r;
        if (y[4]) r = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
        else      r = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) ||
                      (y[3:0] == 4'd8);
        return r;
    endfunction

    function automatic logic [7:0] last_day(input logic [7:0] m,
                                            input logic [7:0] y);
        logic [7:0] r;
        case (m)
            8'h02:                      r = leap(y) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] disp(input logic [7:0] h, input logic f);
        logic [4:0] b;
        logic [4:0] r;
        logic [7:0] o;
        b = 5'(h[3:0]) + (h[4] ? 5'd10 : 5'd0) + (h[5] ? 5'd20 : 5'd0);
        if (b == 5'd0)       r = 5'd12;
        else if (b > 5'd12)  r = b - 5'd12;
        else                 r = b;
        if (!f)              o = h;
        else if (r >= 5'd10) o = {4'd1, 4'(r - 5'd10)};
        else                 o = {4'd0, r[3:0]};
        return o;
    endfunction

    always_comb begin
        sw_chg     = (SW != sw_q);
        presc_wrap = (presc_q == PW'(TICK_DIV - 1));
        tick       = !sw_chg && (presc_wrap || SW == 3'b111);
        presc_d    = (sw_chg || presc_wrap) ? '0 : presc_q + PW'(1);
        sec_d = sec_q; min_d = min_q; hr_d  = hr_q;
        day_d = day_q; mon_d = mon_q; yr_d  = yr_q;
        rh_d  = rh_q;  rm_d  = rm_q;  rs_d  = rs_q;
        fin_d = fin_q; pg_d  = pg_q;  cur_d = cur_q;
        if (sw_chg) begin
            // Mode-entry actions happen on the change edge itself.
            case (SW)
                3'b101: begin
                    hr_d = 8'h11; min_d = 8'h22; sec_d = 8'h33;
                    day_d = 8'h28; mon_d = 8'h02; yr_d = 8'h24;
                end
                3'b110: begin
                    hr_d = 8'h23; min_d = 8'h59; sec_d = 8'h50;
                    day_d = 8'h31; mon_d = 8'h12; yr_d = 8'h99;
                end
                3'b010, 3'b011: begin
                    rh_d = CRON_H; rm_d = CRON_M; rs_d = CRON_S;
                    fin_d = 1'b0;
                end
                default: ;
            endcase
        end else begin
            if (tick && (SW == 3'b001 || SW == 3'b011 || SW == 3'b111)) begin
                if (sec_q != 8'h59) sec_d = bcd_inc(sec_q);
                else begin
                    sec_d = 8'h00;
                    if (min_q != 8'h59) min_d = bcd_inc(min_q);
                    else begin
                        min_d = 8'h00;
                        if (hr_q != 8'h23) hr_d = bcd_inc(hr_q);
                        else begin
                            hr_d = 8'h00;
                            if (day_q != last_day(mon_q, yr_q)) begin
                                day_d = bcd_inc(day_q);
                            end else begin
                                day_d = 8'h01;
                                if (mon_q != 8'h12) mon_d = bcd_inc(mon_q);
                                else begin
                                    mon_d = 8'h01;
                                    yr_d  = (yr_q == 8'h99) ? 8'h00
                                                            : bcd_inc(yr_q);
                                end
                            end
                        end
                    end
                end
            end
            if (SW == 3'b010 || SW == 3'b011) begin
                // A zero count flags done even without a tick.
                if ({rh_q, rm_q, rs_q} == 24'h0) fin_d = 1'b1;
                else if (tick) begin
                    if (rs_q != 8'h00) rs_d = bcd_dec(rs_q);
                    else begin
                        rs_d = 8'h59;
                        if (rm_q != 8'h00) rm_d = bcd_dec(rm_q);
                        else begin
                            rm_d = 8'h59;
                            rh_d = bcd_dec(rh_q);
                        end
                    end
                    if ({rh_d, rm_d, rs_d} == 24'h0) fin_d = 1'b1;
                end
            end
            if (SW == 3'b100 && tick) begin
                pg_d  = pg_q + 2'd1;
                cur_d = (cur_q == 3'(CUR_MAX)) ? 3'd0 : cur_q + 3'd1;
            end
        end
        // Display hour tracks the new hour and the new format together.
        hrel_d = disp(hr_d, fmt12);
        ampm_d = (hr_d >= 8'h12);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q  <= 3'd0;  presc_q <= '0;
            sec_q <= 8'h00; min_q <= 8'h00; hr_q <= 8'h00;
            day_q <= 8'h01; mon_q <= 8'h01; yr_q <= 8'h00;
            rh_q  <= 8'h00; rm_q  <= 8'h00; rs_q <= 8'h00;
            fin_q <= 1'b0;  pg_q  <= 2'd0;  cur_q <= 3'd0;
            fmt_q <= 1'b0;  hrel_q <= 8'h00; ampm_q <= 1'b0;
        end else begin
            sw_q  <= SW;    presc_q <= presc_d;
            sec_q <= sec_d; min_q <= min_d; hr_q <= hr_d;
            day_q <= day_d; mon_q <= mon_d; yr_q <= yr_d;
            rh_q  <= rh_d;  rm_q  <= rm_d;  rs_q <= rs_d;
            fin_q <= fin_d; pg_q  <= pg_d;  cur_q <= cur_d;
            fmt_q <= fmt12; hrel_q <= hrel_d; ampm_q <= ampm_d;
        end
    end

    assign d_pg = pg_q;
    assign p_cr = cur_q;
    assign p_fe = cur_q;
    assign p_ho = cur_q;
    assign CRONO_FIN = fin_q;
    assign AMPM = ampm_q;
    assign FORMATO = fmt_q;
    assign HREL = hrel_q;
    assign MREL = min_q;
    assign SREL = sec_q;
    assign DIA = day_q;
    assign MES = mon_q;
    assign ANIO = yr_q;
    assign HCRON = CRON_H;
    assign MCRON = CRON_M;
    assign SCRON = CRON_S;
    assign HRUN = rh_q;
    assign MRUN = rm_q;
    assign SRUN = rs_q;

endmodule
